generic_digital_gpio_bank: RTL

//   Parametrised bank of NUM_PINS bidirectional digital GPIO cells for the chip-top IO ring.

---
 rtl/generic_digital_gpio_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/generic_digital_gpio_bank.sv
// Bank of NUM_PINS bidirectional GPIO cells: tri-state drive, gated and
// synchronised input, shared-threshold debounce filter, edge-triggered
// sticky interrupt flags and a single ORed interrupt line.
module generic_digital_gpio_bank #(
    parameter int NUM_PINS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    inout  wire  [NUM_PINS-1:0] pad,
    input  logic [NUM_PINS-1:0] o,
    input  logic [NUM_PINS-1:0] oe,
    input  logic [NUM_PINS-1:0] ie,
    output logic [NUM_PINS-1:0] i,
    input  logic [DB_W-1:0]     db_limit,
    input  logic [NUM_PINS-1:0] rise_en,
    input  logic [NUM_PINS-1:0] fall_en,
    input  logic [NUM_PINS-1:0] irq_clear,
    output logic [NUM_PINS-1:0] irq_pending,
    output logic                irq
);

    logic [NUM_PINS-1:0] raw;
    logic [NUM_PINS-1:0] sync_chain [SYNC_STAGES];
    logic [NUM_PINS-1:0] s;
    logic [NUM_PINS-1:0] filt;
    logic [DB_W-1:0]     cnt      [NUM_PINS];
    logic [DB_W-1:0]     cnt_next [NUM_PINS];
    logic [NUM_PINS-1:0] upd;
    logic [NUM_PINS-1:0] set;
    logic [NUM_PINS-1:0] pending;

    // Output drivers are purely combinational so the pad is released
    // regardless of the reset state of the rest of the bank.
    for (genvar k = 0; k < NUM_PINS; k++) begin : g_drive
        assign pad[k] = oe[k] ? o[k] : 1'bz;
    end

    // A disabled input reads as 0, which lets a held-high filter decay to 0.
    assign raw = ie & pad;
    assign s   = sync_chain[SYNC_STAGES-1];

    // Synchroniser chain: one flop per pin per stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int st = 0; st < SYNC_STAGES; st++) begin
                sync_chain[st] <= '0;
            end
        end else begin
            sync_chain[0] <= raw;
            for (int st = 1; st < SYNC_STAGES; st++) begin
                sync_chain[st] <= sync_chain[st-1];
            end
        end
    end

    // Debounce decision: count consecutive mismatches, accept the new level
    // once the count has reached the limit (>= so a lowered limit never wraps).
    always_comb begin
        upd = '0;
        for (int k = 0; k < NUM_PINS; k++) begin
            cnt_next[k] = '0;
        end
        for (int k = 0; k < NUM_PINS; k++) begin
            if (s[k] != filt[k]) begin
                if (cnt[k] >= db_limit) begin
                    upd[k]      = 1'b1;
                    cnt_next[k] = '0;
                end else begin
                    upd[k]      = 1'b0;
                    cnt_next[k] = cnt[k] + DB_W'(1);
                end
            end else begin
                upd[k]      = 1'b0;
                cnt_next[k] = '0;
            end
        end
        set = upd & ((s & rise_en) | (~s & fall_en));
    end

    // Debounce counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_PINS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PINS; k++) begin
                cnt[k] <= cnt_next[k];
            end
        end
    end

    // Filtered level: flips only on an accepted debounce update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
        end else begin
            filt <= filt ^ upd;
        end
    end

    // Sticky interrupt flags; a new edge wins over a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= set | (pending & ~irq_clear);
        end
    end

    assign i           = filt;
    assign irq_pending = pending;
    assign irq         = |pending;

endmodule
